// File: rtl/calc_sequencer.sv
// Command sequencer for an external combinational 5-bit calculator: queues
// {op, A, B} commands in a FIFO, issues them one at a time and holds each result until it is taken.
module calc_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [4:0]                    cmd_a,
    input  logic [4:0]                    cmd_b,
    input  logic [1:0]                    cmd_op,
    output logic [4:0]                    alu_A,
    output logic [4:0]                    alu_B,
    output logic [1:0]                    alu_a_s,
    input  logic [8:0]                    alu_result,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [8:0]                    res_data,
    output logic [1:0]                    res_op,
    output logic                          res_err,
    output logic                          res_ovf,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state;
    state_t         next_state;
    logic [11:0]    mem [FIFO_DEPTH];
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [11:0]    head_entry;
    logic           push;
    logic           pop;

    assign cmd_ready  = (fifo_count != CW'(FIFO_DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign head_entry = mem[head];
    assign res_valid  = (state == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // A pop happens whenever the FSM is about to enter EXEC; RESP chains straight into the next command.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop        = 1'b1;
                    next_state = EXEC;
                end
            end
            EXEC: next_state = RESP;
            RESP: begin
                if (res_ready) begin
                    if (fifo_count != '0) begin
                        pop        = 1'b1;
                        next_state = EXEC;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head       <= '0;
            tail       <= '0;
            fifo_count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= {cmd_op, cmd_a, cmd_b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_A   <= '0;
            alu_B   <= '0;
            alu_a_s <= '0;
        end else if (pop) begin
            alu_a_s <= head_entry[11:10];
            alu_A   <= head_entry[9:5];
            alu_B   <= head_entry[4:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data <= '0;
            res_op   <= '0;
            res_err  <= 1'b0;
            res_ovf  <= 1'b0;
        end else if (state == EXEC) begin
            res_data <= alu_result;
            res_op   <= alu_a_s;
            res_err  <= (alu_a_s == 2'b11) && (alu_B == 5'd0);
            res_ovf  <= (alu_a_s == 2'b10) && (alu_A == 5'b10000) && (alu_B == 5'b10000);
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer; a behavioural calculator
// answers the ALU port and every expected result is a hand-computed constant.
module tb_calc_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [4:0] cmd_a;
    logic [4:0] cmd_b;
    logic [1:0] cmd_op;
    logic [4:0] alu_A;
    logic [4:0] alu_B;
    logic [1:0] alu_a_s;
    logic [8:0] alu_result;
    logic       res_valid;
    logic       res_ready;
    logic [8:0] res_data;
    logic [1:0] res_op;
    logic       res_err;
    logic       res_ovf;
    logic [2:0] fifo_count;

    int total;
    int bad;
    int ia;
    int ib;
    int ir;

    logic signed [31:0] got      [8];
    logic               got_err  [8];
    int                 got_cyc  [8];
    int                 n;
    int                 seen;
    logic               acc;
    logic               sent;

    calc_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_a_s    (alu_a_s),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_op     (res_op),
        .res_err    (res_err),
        .res_ovf    (res_ovf),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Calculator contract: 9-bit wrap on multiply, divide by zero yields 0.
    always_comb begin
        ia = $signed(alu_A);
        ib = $signed(alu_B);
        ir = 0;
        case (alu_a_s)
            2'b00: ir = ia + ib;
            2'b01: ir = ia - ib;
            2'b10: ir = ia * ib;
            2'b11: ir = (ib == 0) ? 0 : ia / ib;
            default: ir = 0;
        endcase
        alu_result = ir[8:0];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [1:0] op, input int a, input int b);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = 5'(a);
        cmd_b     = 5'(b);
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = '0;
        res_ready = 1'b0;

        #3;
        check("rst_count", fifo_count, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_valid", res_valid, 0);
        check("rst_data", $signed(res_data), 0);
        check("rst_alu_a", alu_A, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single add accepted on the first edge after reset release
        $display("[TB] single add");
        res_ready = 1'b1;
        drive_cmd(2'b00, 8, 7);
        tick();
        cmd_valid = 1'b0;
        check("add_count_n", fifo_count, 1);
        check("add_valid_n", res_valid, 0);
        tick();
        check("add_valid_n1", res_valid, 0);
        check("add_alu_a", $signed(alu_A), 8);
        tick();
        check("add_valid_n2", res_valid, 1);
        check("add_data", $signed(res_data), 15);
        check("add_err", res_err, 0);
        check("add_ovf", res_ovf, 0);
        tick();
        check("add_valid_drop", res_valid, 0);

        // Four back-to-back commands, results one every two cycles
        $display("[TB] back-to-back");
        n = 0;
        for (int i = 0; i < 12; i++) begin
            case (i)
                0: drive_cmd(2'b01, 10, 3);
                1: drive_cmd(2'b01, -8, -4);
                2: drive_cmd(2'b10, 4, 3);
                3: drive_cmd(2'b10, -6, 2);
                default: cmd_valid = 1'b0;
            endcase
            if (res_valid && res_ready && n < 8) begin
                got[n]     = $signed(res_data);
                got_cyc[n] = i;
                n++;
            end
            tick();
        end
        check("b2b_n", n, 4);
        check("b2b_r0", got[0], 7);
        check("b2b_r1", got[1], -4);
        check("b2b_r2", got[2], 12);
        check("b2b_r3", got[3], -12);
        check("b2b_gap1", got_cyc[1] - got_cyc[0], 2);
        check("b2b_gap3", got_cyc[3] - got_cyc[2], 2);

        // Fill: one command lands in RESP, four more fill the FIFO, the sixth waits
        $display("[TB] fill");
        res_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            drive_cmd(2'b00, k, k);
            check("fill_ready", cmd_ready, 1);
            tick();
        end
        cmd_valid = 1'b0;
        check("fill_count", fifo_count, 4);
        check("fill_ready_low", cmd_ready, 0);
        check("fill_first", $signed(res_data), 2);
        drive_cmd(2'b00, 6, 6);
        repeat (3) tick();
        check("fill_held_count", fifo_count, 4);
        check("fill_held_data", $signed(res_data), 2);
        res_ready = 1'b1;
        n    = 0;
        sent = 1'b0;
        for (int i = 0; i < 30; i++) begin
            acc = cmd_valid && cmd_ready;
            if (res_valid && res_ready && n < 8) begin
                got[n] = $signed(res_data);
                n++;
            end
            tick();
            if (acc) begin
                cmd_valid = 1'b0;
                sent      = 1'b1;
            end
        end
        check("fill_sixth_sent", sent, 1);
        check("fill_n", n, 6);
        for (int k = 0; k < 6; k++) check("fill_order", got[k], 2 * (k + 1));
        check("fill_empty", fifo_count, 0);

        // Divide by zero followed by a normal divide
        $display("[TB] divide");
        n = 0;
        for (int i = 0; i < 10; i++) begin
            case (i)
                0: drive_cmd(2'b11, 7, 0);
                1: drive_cmd(2'b11, -8, 2);
                default: cmd_valid = 1'b0;
            endcase
            if (res_valid && res_ready && n < 8) begin
                got[n]     = $signed(res_data);
                got_err[n] = res_err;
                n++;
            end
            tick();
        end
        check("div_n", n, 2);
        check("div0_data", got[0], 0);
        check("div0_err", got_err[0], 1);
        check("div_data", got[1], -4);
        check("div_err", got_err[1], 0);

        // Overflowing multiply held while the consumer stalls
        $display("[TB] multiply overflow");
        res_ready = 1'b0;
        drive_cmd(2'b10, -16, -16);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) if (!res_valid) tick();
        check("mul_valid", res_valid, 1);
        check("mul_ovf", res_ovf, 1);
        check("mul_data", $signed(res_data), -256);
        check("mul_op", res_op, 2);
        check("mul_err", res_err, 0);
        repeat (5) tick();
        check("mul_hold_valid", res_valid, 1);
        check("mul_hold_data", $signed(res_data), -256);
        check("mul_hold_ovf", res_ovf, 1);
        res_ready = 1'b1;
        tick();
        check("mul_release", res_valid, 0);
        tick();
        check("alu_hold_a", $signed(alu_A), -16);
        check("alu_hold_op", alu_a_s, 2);

        // Reset asserted in RESP with three commands still queued
        $display("[TB] reset mid-operation");
        res_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_cmd(2'b00, 9, k);
            tick();
        end
        cmd_valid = 1'b0;
        check("pre_rst_valid", res_valid, 1);
        check("pre_rst_count", fifo_count, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", res_valid, 0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_data", $signed(res_data), 0);
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_alu_a", alu_A, 0);
        check("mid_rst_op", res_op, 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        res_ready = 1'b1;
        seen      = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (res_valid) seen++;
        end
        check("post_rst_stale", seen, 0);
        check("post_rst_count", fifo_count, 0);
        drive_cmd(2'b00, 3, 4);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("post_rst_valid", res_valid, 1);
        check("post_rst_data", $signed(res_data), 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
